nios_sample_writer: RTL and testbench

Avalon-MM write master that takes 32-bit sensor samples from a valid/ready stream and stores them as a circular buffer in the Nios on-chip memory. It sits between the GY-85 sensor capture logic and the on-chip RAM's data slave, so samples land in memory without CPU copies. The CPU learns progress through a write pointer, a sticky wrap flag and a threshold interrupt.

---
 rtl/nios_sample_pkg.sv | 18 +
 rtl/nios_sample_fifo.sv | 82 ++++++++
 rtl/nios_sample_writer.sv | 172 +++++++++++++++++
 tb/tb_nios_sample_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_sample_pkg.sv
// Shared types and constants for the Nios sample ring writer.
// The FSM encoding, the byte-enable constant and the irq counter sizing live here.
package nios_sample_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE      = 2'd1,
        S_CLEAR_WAIT = 2'd2
    } state_e;

    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

    // Counter holds 0..every-1, so $clog2(every) bits suffice; keep at least one bit.
    function automatic int irq_cnt_width(input int every);
        return (every < 2) ? 1 : $clog2(every);
    endfunction

endpackage

// File: rtl/nios_sample_fifo.sv
// Small synchronous skid FIFO between the sensor stream and the Avalon master.
// Full is registered so the upstream ready never sees a same-cycle pop.
module nios_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] rd_data_nxt,
    output logic          full,
    output logic          empty,
    output logic          one,
    output logic          many
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;

    assign do_push    = push & ~full_q & ~flush;
    assign do_pop     = pop & (cnt_q != '0) & ~flush;
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        full_d = (cnt_d == CW'(DEPTH));
    end

    // Full resets high so the stream sees ready=0 until the first clock after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign rd_data_nxt = mem_q[rd_ptr_nxt];
    assign full        = full_q;
    assign empty       = (cnt_q == '0);
    assign one         = (cnt_q == CW'(1));
    assign many        = (cnt_q > CW'(1));

endmodule

// File: rtl/nios_sample_writer.sv
// Avalon-MM write master that drains sensor samples into a circular buffer
// in on-chip RAM, tracking write pointer, wrap flag and a threshold irq.
module nios_sample_writer
    import nios_sample_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_WORDS = 10024,
    parameter int FIFO_DEPTH  = 4,
    parameter int IRQ_EVERY   = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       st_data,
    input  logic              st_valid,
    output logic              st_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic              ctl_enable,
    input  logic              ctl_clear,
    input  logic              irq_ack,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic              irq
);

    localparam int                CNT_W     = irq_cnt_width(IRQ_EVERY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(IRQ_EVERY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] ptr_inc;
    logic [31:0]       data_q, data_d;
    logic              write_q, write_d;
    logic              wrapped_q, wrapped_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              fifo_full, fifo_empty, fifo_one, fifo_many;
    logic [31:0]       fifo_head, fifo_head_nxt;
    logic              push, done, do_clear, start, cont, wrap, hit;
    logic              avail_idle, avail_wr;
    logic [31:0]       idle_data, next_data;

    nios_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (32)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (st_valid),
        .pop         (done),
        .flush       (do_clear),
        .wr_data     (st_data),
        .rd_data     (fifo_head),
        .rd_data_nxt (fifo_head_nxt),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .one         (fifo_one),
        .many        (fifo_many)
    );

    assign push    = st_valid & ~fifo_full;
    assign done    = (state_q != S_IDLE) & ~avm_waitrequest;
    assign wrap    = (wr_ptr_q == LAST_ADDR);
    assign ptr_inc = wrap ? '0 : wr_ptr_q + ADDR_W'(1);
    assign hit     = done & (cnt_q == LAST_CNT);

    // The in-flight word stays at the FIFO head until it completes, so the
    // follow-on word is the entry behind it, or the sample arriving right now.
    assign avail_idle = ~fifo_empty | push;
    assign idle_data  = fifo_empty ? st_data : fifo_head;
    assign avail_wr   = fifo_many | (fifo_one & push);
    assign next_data  = fifo_many ? fifo_head_nxt : st_data;

    assign start    = (state_q == S_IDLE) & ctl_enable & ~ctl_clear & avail_idle;
    assign cont     = (state_q == S_WRITE) & done & ctl_enable & ~ctl_clear & avail_wr;
    assign do_clear = ((state_q == S_IDLE) & ctl_clear)
                    | ((state_q == S_WRITE) & ctl_clear & done)
                    | ((state_q == S_CLEAR_WAIT) & done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (ctl_clear)  state_d = done ? S_IDLE : S_CLEAR_WAIT;
                else if (done)  state_d = cont ? S_WRITE : S_IDLE;
            end
            S_CLEAR_WAIT: begin
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        write_d   = write_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        if (start) begin
            write_d = 1'b1;
            addr_d  = wr_ptr_q;
            data_d  = idle_data;
        end else if (cont) begin
            write_d = 1'b1;
            addr_d  = ptr_inc;
            data_d  = next_data;
        end else if (done) begin
            write_d = 1'b0;
        end
        if (done) begin
            wr_ptr_d = ptr_inc;
            if (wrap) wrapped_d = 1'b1;
            cnt_d = hit ? '0 : cnt_q + CNT_W'(1);
        end
        // A threshold hit in the ack cycle must not be lost.
        if (irq_ack) irq_d = 1'b0;
        if (hit)     irq_d = 1'b1;
        if (do_clear) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
            cnt_d     = '0;
            irq_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            wrapped_q <= wrapped_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign st_ready       = ~fifo_full;
    assign avm_write      = write_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = BYTEENABLE_ALL;
    assign wr_ptr         = wr_ptr_q;
    assign wrapped        = wrapped_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_nios_sample_writer.sv
// Directed bench for nios_sample_writer: ring of 8 words, irq every 4 writes.
module tb_nios_sample_writer;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   st_data = '0;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [AW-1:0] avm_address;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest = 1'b0;
    logic          ctl_enable = 1'b0;
    logic          ctl_clear = 1'b0;
    logic          irq_ack = 1'b0;
    logic [AW-1:0] wr_ptr;
    logic          wrapped;
    logic          irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic        ww[$];

    nios_sample_writer #(
        .ADDR_W      (AW),
        .DEPTH_WORDS (8),
        .FIFO_DEPTH  (4),
        .IRQ_EVERY   (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .ctl_enable      (ctl_enable),
        .ctl_clear       (ctl_clear),
        .irq_ack         (irq_ack),
        .wr_ptr          (wr_ptr),
        .wrapped         (wrapped),
        .irq             (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every completed Avalon write, with the wrap flag seen during it.
    always @(negedge clk) begin
        if (reset_n && avm_write && !avm_waitrequest) begin
            wa.push_back(int'(avm_address));
            wd.push_back(avm_writedata);
            wc.push_back(cyc);
            ww.push_back(wrapped);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_log();
        wa.delete(); wd.delete(); wc.delete(); ww.delete();
    endtask

    task automatic rst();
        reset_n = 1'b0;
        st_valid = 1'b0; st_data = '0; ctl_enable = 1'b0; ctl_clear = 1'b0;
        irq_ack = 1'b0; avm_waitrequest = 1'b0;
        tick(2);
        clr_log();
        reset_n = 1'b1;
        tick(1);
    endtask

    // Holds st_valid until the handshake edge; returns just after that edge.
    task automatic push(input logic [31:0] w, output int pc);
        bit ok;
        ok = 1'b0;
        st_data = w;
        st_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = st_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("push_timeout", 32'(st_ready), 32'd1);
        pc = cyc;
    endtask

    task automatic chk_wr(input int k, input int a, input logic [31:0] d);
        if (k < wa.size()) begin
            chk($sformatf("wr%0d_addr", k), 32'(wa[k]), 32'(a));
            chk($sformatf("wr%0d_data", k), wd[k], d);
        end else begin
            chk($sformatf("wr%0d_present", k), 32'(wa.size()), 32'(k + 1));
        end
    endtask

    initial begin
        int pc, p0;

        // Reset values, sampled while reset is held.
        reset_n = 1'b0;
        tick(2);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_data", avm_writedata, 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'hF);
        chk("rst_ready", 32'(st_ready), 32'd0);
        chk("rst_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        tick(1);
        chk("rst_ready_after", 32'(st_ready), 32'd1);

        // Streaming at zero wait.
        rst();
        ctl_enable = 1'b1;
        push(32'hA0, p0);
        push(32'hA1, pc);
        push(32'hA2, pc);
        st_valid = 1'b0;
        tick(5);
        chk("stream_n", 32'(wa.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk_wr(i, i, 32'hA0 + 32'(i));
        if (wa.size() == 3) begin
            chk("stream_latency", 32'(wc[0]), 32'(p0));
            chk("stream_gap", 32'(wc[2] - wc[0]), 32'd2);
        end
        chk("stream_ptr", 32'(wr_ptr), 32'd3);

        // Backpressure: first write stalled for 5 cycles.
        rst();
        ctl_enable = 1'b1;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'hB0 + 32'(i), pc);
            chk($sformatf("bp_hold%0d_wr", i), 32'(avm_write), 32'd1);
            chk($sformatf("bp_hold%0d_addr", i), 32'(avm_address), 32'd0);
            chk($sformatf("bp_hold%0d_data", i), avm_writedata, 32'hB0);
        end
        chk("bp_full_ready", 32'(st_ready), 32'd0);
        tick(1);
        chk("bp_hold4_addr", 32'(avm_address), 32'd0);
        chk("bp_hold4_data", avm_writedata, 32'hB0);
        chk("bp_full_ready2", 32'(st_ready), 32'd0);
        chk("bp_none_done", 32'(wa.size()), 32'd0);
        avm_waitrequest = 1'b0;
        push(32'hB4, pc);
        st_valid = 1'b0;
        tick(8);
        chk("bp_n", 32'(wa.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk_wr(i, i, 32'hB0 + 32'(i));
        chk("bp_ptr", 32'(wr_ptr), 32'd5);

        // Wrap on an 8-word ring.
        rst();
        ctl_enable = 1'b1;
        for (int i = 0; i < 10; i++) push(32'hC0 + 32'(i), pc);
        st_valid = 1'b0;
        tick(6);
        chk("wrap_n", 32'(wa.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk_wr(i, i % 8, 32'hC0 + 32'(i));
        if (ww.size() == 10) begin
            chk("wrap_flag_w8", 32'(ww[7]), 32'd0);
            chk("wrap_flag_w9", 32'(ww[8]), 32'd1);
        end
        chk("wrap_ptr", 32'(wr_ptr), 32'd2);
        chk("wrap_sticky", 32'(wrapped), 32'd1);

        // Interrupt every 4 writes, ack priority.
        rst();
        ctl_enable = 1'b1;
        for (int i = 0; i < 3; i++) push(32'hD0 + 32'(i), pc);
        st_valid = 1'b0;
        tick(4);
        chk("irq_after3", 32'(irq), 32'd0);
        push(32'hD3, pc);
        st_valid = 1'b0;
        tick(3);
        chk("irq_after4", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("irq_acked", 32'(irq), 32'd0);
        for (int i = 4; i < 7; i++) push(32'hD0 + 32'(i), pc);
        st_valid = 1'b0;
        tick(4);
        chk("irq_after7", 32'(irq), 32'd0);
        push(32'hD7, pc);
        st_valid = 1'b0;
        chk("irq_pre8", 32'(irq), 32'd0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("irq_hit_beats_ack", 32'(irq), 32'd1);
        push(32'hD8, pc);
        st_valid = 1'b0;
        tick(3);
        chk("irq_after9", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("irq_acked2", 32'(irq), 32'd0);
        chk("irq_ptr", 32'(wr_ptr), 32'd1);

        // Clear while a write is stalled, after wrapping and raising irq.
        rst();
        ctl_enable = 1'b1;
        for (int i = 0; i < 9; i++) push(32'hE0 + 32'(i), pc);
        st_valid = 1'b0;
        tick(6);
        chk("clr_pre_ptr", 32'(wr_ptr), 32'd1);
        chk("clr_pre_wrapped", 32'(wrapped), 32'd1);
        chk("clr_pre_irq", 32'(irq), 32'd1);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) push(32'hF0 + 32'(i), pc);
        st_valid = 1'b0;
        ctl_clear = 1'b1;
        tick(1);
        ctl_clear = 1'b0;
        tick(1);
        chk("clr_inflight_wr", 32'(avm_write), 32'd1);
        chk("clr_inflight_addr", 32'(avm_address), 32'd1);
        avm_waitrequest = 1'b0;
        tick(10);
        chk("clr_n", 32'(wa.size()), 32'd10);
        chk_wr(9, 1, 32'hF0);
        chk("clr_ptr", 32'(wr_ptr), 32'd0);
        chk("clr_wrapped", 32'(wrapped), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);
        chk("clr_idle", 32'(avm_write), 32'd0);
        chk("clr_ready", 32'(st_ready), 32'd1);

        // Disabled: FIFO fills, nothing written until enabled.
        rst();
        for (int i = 0; i < 4; i++) push(32'h50 + 32'(i), pc);
        st_valid = 1'b0;
        chk("dis_ready", 32'(st_ready), 32'd0);
        tick(5);
        chk("dis_no_writes", 32'(wa.size()), 32'd0);
        ctl_enable = 1'b1;
        tick(8);
        chk("dis_n", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_wr(i, i, 32'h50 + 32'(i));
        if (wc.size() == 4) chk("dis_gap", 32'(wc[3] - wc[0]), 32'd3);
        chk("dis_ptr", 32'(wr_ptr), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
